// File: rtl/i2c_req_arbiter_if.sv
// ============================================================================
// Module   : i2c_req_arbiter_if
// Summary  : Wishbone master/slave bundle between the arbiter and the I2C master.
// Revision : 1.0 initial release
// ============================================================================
`default_nettype none

interface i2c_req_arbiter_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [5:0]  addr;
   logic [31:0] wdata;
   logic [3:0]  sel;
   logic        ack;
   logic        stall;
   logic [31:0] rdata;

   modport master (
      output cyc, stb, we, addr, wdata, sel,
      input  ack, stall, rdata
   );

   modport slave (
      input  cyc, stb, we, addr, wdata, sel,
      output ack, stall, rdata
   );
endinterface

`default_nettype wire

// File: rtl/i2c_req_arbiter.sv
// ============================================================================
// Module   : i2c_req_arbiter
// Summary  : Round-robin sharing of one Wishbone I2C master among NREQ requesters.
// Options  : I2CARB_TIMEOUT_EN enables the status-poll abort limit.
// Revision : 1.0 initial release
// ============================================================================
`default_nettype none

module i2c_req_arbiter #(
   parameter int          NREQ          = 4,
   parameter int          POLL_CYCLES   = 16,
   parameter logic [15:0] TIMEOUT_POLLS = 16'd4096
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [NREQ-1:0]      i_req,
   input  logic [32*NREQ-1:0]   i_cmd,
   output logic [NREQ-1:0]      o_grant,
   output logic [NREQ-1:0]      o_done,
   output logic [31:0]          o_status,
   output logic                 o_timeout,
   output logic                 o_busy,
   i2c_req_arbiter_if.master    wb
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = $clog2(POLL_CYCLES);
   localparam logic [CW-1:0]   C_POLL_RELOAD = CW'(POLL_CYCLES - 1);
   localparam logic [PW-1:0]   C_PTR_RESET   = PW'(NREQ - 1);
   localparam logic [NREQ-1:0] C_ONE         = NREQ'(1);
   localparam logic [31:0]     C_TMO_FLAG    = 32'h2000_0000;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WRCMD  = 3'd1,
      S_WAIT   = 3'd2,
      S_RDSTAT = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [PW-1:0]   r_ptr, w_ptr_nxt;
   logic [NREQ-1:0] r_grant, w_grant_nxt;
   logic [NREQ-1:0] r_done, w_done_nxt;
   logic [31:0]     r_status, w_status_nxt;
   logic            r_cyc, w_cyc_nxt;
   logic            r_stb, w_stb_nxt;
   logic            r_we, w_we_nxt;
   logic [31:0]     r_wdata, w_wdata_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;

`ifdef I2CARB_TIMEOUT_EN
   logic [15:0]     r_polls, w_polls_nxt;
   logic            r_tmo, w_tmo_nxt;
`endif

   logic            w_found;
   logic [PW-1:0]   w_pick;
   logic [PW-1:0]   w_scan;
   logic [31:0]     w_cmd_sel;

   // Round-robin scan starting one past the last winner.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_scan  = '0;
      for (int i = 1; i <= NREQ; i++) begin
         w_scan = PW'((int'(r_ptr) + i) % NREQ);
         if (!w_found && i_req[w_scan]) begin
            w_found = 1'b1;
            w_pick  = w_scan;
         end
      end
   end

   always_comb begin
      w_cmd_sel = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (w_pick == PW'(k)) begin
            w_cmd_sel = i_cmd[32*k +: 32];
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_ptr_nxt    = r_ptr;
      w_grant_nxt  = r_grant;
      w_done_nxt   = '0;
      w_status_nxt = r_status;
      w_cyc_nxt    = r_cyc;
      w_stb_nxt    = r_stb;
      w_we_nxt     = r_we;
      w_wdata_nxt  = r_wdata;
      w_cnt_nxt    = r_cnt;
`ifdef I2CARB_TIMEOUT_EN
      w_polls_nxt  = r_polls;
      w_tmo_nxt    = 1'b0;
`endif

      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_nxt = S_WRCMD;
               w_ptr_nxt   = w_pick;
               w_grant_nxt = C_ONE << w_pick;
               w_cyc_nxt   = 1'b1;
               w_stb_nxt   = 1'b1;
               w_we_nxt    = 1'b1;
               w_wdata_nxt = w_cmd_sel;
`ifdef I2CARB_TIMEOUT_EN
               w_polls_nxt = '0;
`endif
            end
         end

         S_WRCMD: begin
            if (r_stb && !wb.stall) begin
               w_stb_nxt = 1'b0;
            end
            if (wb.ack) begin
               w_cyc_nxt   = 1'b0;
               w_stb_nxt   = 1'b0;
               w_we_nxt    = 1'b0;
               w_cnt_nxt   = C_POLL_RELOAD;
               w_state_nxt = S_WAIT;
            end
         end

         S_WAIT: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_RDSTAT;
               w_cyc_nxt   = 1'b1;
               w_stb_nxt   = 1'b1;
               w_we_nxt    = 1'b0;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end

         S_RDSTAT: begin
            if (r_stb && !wb.stall) begin
               w_stb_nxt = 1'b0;
            end
            if (wb.ack) begin
               w_cyc_nxt    = 1'b0;
               w_stb_nxt    = 1'b0;
               w_status_nxt = wb.rdata;
               if (wb.rdata[31]) begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt   = C_POLL_RELOAD;
`ifdef I2CARB_TIMEOUT_EN
                  w_polls_nxt = r_polls + 16'd1;
                  // Abort: report the last busy word with the timeout flag set.
                  if (r_polls + 16'd1 == TIMEOUT_POLLS) begin
                     w_state_nxt  = S_DONE;
                     w_status_nxt = wb.rdata | C_TMO_FLAG;
                     w_done_nxt   = r_grant;
                     w_grant_nxt  = '0;
                     w_tmo_nxt    = 1'b1;
                  end
`endif
               end else begin
                  w_state_nxt = S_DONE;
                  w_done_nxt  = r_grant;
                  w_grant_nxt = '0;
               end
            end
         end

         S_DONE: begin
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_ptr    <= C_PTR_RESET;
         r_grant  <= '0;
         r_done   <= '0;
         r_status <= '0;
         r_cyc    <= 1'b0;
         r_stb    <= 1'b0;
         r_we     <= 1'b0;
         r_wdata  <= '0;
         r_cnt    <= '0;
`ifdef I2CARB_TIMEOUT_EN
         r_polls  <= '0;
         r_tmo    <= 1'b0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_ptr    <= w_ptr_nxt;
         r_grant  <= w_grant_nxt;
         r_done   <= w_done_nxt;
         r_status <= w_status_nxt;
         r_cyc    <= w_cyc_nxt;
         r_stb    <= w_stb_nxt;
         r_we     <= w_we_nxt;
         r_wdata  <= w_wdata_nxt;
         r_cnt    <= w_cnt_nxt;
`ifdef I2CARB_TIMEOUT_EN
         r_polls  <= w_polls_nxt;
         r_tmo    <= w_tmo_nxt;
`endif
      end
   end

   assign o_grant  = r_grant;
   assign o_done   = r_done;
   assign o_status = r_status;
   assign o_busy   = (r_state != S_IDLE);

`ifdef I2CARB_TIMEOUT_EN
   assign o_timeout = r_tmo;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^TIMEOUT_POLLS;
   assign o_timeout        = 1'b0;
`endif

   assign wb.cyc   = r_cyc;
   assign wb.stb   = r_stb;
   assign wb.we    = r_we;
   assign wb.addr  = 6'd0;
   assign wb.wdata = r_wdata;
   assign wb.sel   = r_cyc ? 4'hf : 4'h0;

endmodule

`default_nettype wire

// File: tb/tb_i2c_req_arbiter.sv
// Testbench for i2c_req_arbiter: Wishbone slave model plus a completion scoreboard.
`default_nettype none

module tb_i2c_req_arbiter;
   localparam int          NREQ      = 4;
   localparam int          POLL      = 4;
   localparam logic [31:0] BUSY_WORD = 32'h8000_00AA;

   typedef struct {
      logic [3:0]  done;
      logic [31:0] status;
      logic        tmo;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [NREQ-1:0] req;
   logic [127:0]    cmd;
   logic [NREQ-1:0] d_grant, d_done;
   logic [31:0]     d_status;
   logic            d_tmo, d_busy;
   logic            stall_drv;

   int total = 0, bad = 0;
   int done_cnt = 0, wr_cnt = 0, rd_cnt = 0, rd_in_txn = 0;
   int busy_reads = 0;
   bit echo = 1'b0;
   logic [31:0] final_status = '0;
   logic [31:0] last_w = '0;
   logic [31:0] wr_log[$];
   int          grant_log[$];
   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [3:0]  prev_grant = '0;

   i2c_req_arbiter_if wb();

   i2c_req_arbiter #(
      .NREQ(NREQ), .POLL_CYCLES(POLL), .TIMEOUT_POLLS(16'd8)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_cmd(cmd),
      .o_grant(d_grant), .o_done(d_done), .o_status(d_status),
      .o_timeout(d_tmo), .o_busy(d_busy), .wb(wb)
   );

   always #5 clk = ~clk;

   assign wb.stall = stall_drv;

   // Slave: acks one cycle after an accepted strobe; status busy for busy_reads reads.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         wb.ack    <= 1'b0;
         wb.rdata  <= '0;
         rd_in_txn <= 0;
      end else begin
         wb.ack <= 1'b0;
         if (wb.cyc && wb.stb && !wb.stall) begin
            wb.ack <= 1'b1;
            if (wb.we) begin
               wr_cnt    <= wr_cnt + 1;
               wr_log.push_back(wb.wdata);
               last_w    <= wb.wdata;
               rd_in_txn <= 0;
               wb.rdata  <= '0;
            end else begin
               rd_cnt    <= rd_cnt + 1;
               rd_in_txn <= rd_in_txn + 1;
               if (rd_in_txn < busy_reads) wb.rdata <= BUSY_WORD;
               else if (echo)              wb.rdata <= {8'h00, last_w[23:0]};
               else                        wb.rdata <= final_status;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         prev_grant = '0;
      end else begin
         if (d_done !== 4'b0000) begin
            done_cnt++;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL sb_extra: done=%b status=%h but nothing expected", d_done, d_status);
            end else begin
               mon_e = exp_q.pop_front();
               if (d_done !== mon_e.done || d_status !== mon_e.status || d_tmo !== mon_e.tmo) begin
                  bad++;
                  $display("FAIL sb_done: got done=%b status=%h tmo=%b, want done=%b status=%h tmo=%b",
                           d_done, d_status, d_tmo, mon_e.done, mon_e.status, mon_e.tmo);
               end
            end
         end
         if (d_grant !== 4'b0000 && d_grant !== prev_grant) begin
            total++;
            if (!$onehot(d_grant) || prev_grant !== 4'b0000) begin
               bad++;
               $display("FAIL grant_shape: grant=%b prev=%b, want one-hot after idle", d_grant, prev_grant);
            end
            for (int k = 0; k < NREQ; k++) if (d_grant[k]) grant_log.push_back(k);
         end
         prev_grant = d_grant;
      end
   end

   task automatic test_reset();
      rst = 1'b1; req = '0; cmd = '0; stall_drv = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({d_grant, d_done, d_tmo, d_busy} !== 10'd0) begin
         bad++; $display("FAIL reset_ctrl: grant=%b done=%b tmo=%b busy=%b, want 0", d_grant, d_done, d_tmo, d_busy);
      end
      total++;
      if ({wb.cyc, wb.stb, wb.we, wb.sel, wb.addr, wb.wdata} !== 45'd0) begin
         bad++; $display("FAIL reset_bus: cyc=%b stb=%b we=%b sel=%h data=%h, want 0", wb.cyc, wb.stb, wb.we, wb.sel, wb.wdata);
      end
      total++;
      if (d_status !== 32'h0) begin
         bad++; $display("FAIL reset_status: got %h want 0", d_status);
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      int n, w0, r0;
      w0 = wr_cnt; r0 = rd_cnt;
      busy_reads = 3; echo = 1'b0; final_status = 32'h0000_0055;
      cmd[63:32] = 32'h00A1_0004;
      exp_q.push_back('{done: 4'b0010, status: 32'h0000_0055, tmo: 1'b0});
      @(negedge clk); req = 4'b0010;
      @(negedge clk);
      total++;
      if (d_grant !== 4'b0010 || wb.cyc !== 1'b1 || wb.stb !== 1'b1 || wb.we !== 1'b1 || wb.wdata !== 32'h00A10004) begin
         bad++; $display("FAIL grant_latency: grant=%b cyc=%b stb=%b we=%b data=%h, want 0010/1/1/1/00a10004",
                         d_grant, wb.cyc, wb.stb, wb.we, wb.wdata);
      end
      req = '0;
      n = 0;
      while (d_done === 4'b0000 && n < 300) begin @(negedge clk); n++; end
      total++;
      if (n != 26) begin
         bad++; $display("FAIL single_latency: done after %0d cycles, want 26", n);
      end
      @(negedge clk);
      total++;
      if (wr_cnt - w0 != 1 || wr_log.size() == 0 || wr_log[$] !== 32'h00A10004) begin
         bad++; $display("FAIL single_write: writes=%0d, want one write of 00a10004", wr_cnt - w0);
      end
      total++;
      if (rd_cnt - r0 != 4) begin
         bad++; $display("FAIL single_reads: got %0d want 4", rd_cnt - r0);
      end
      total++;
      if (d_busy !== 1'b0 || d_done !== 4'b0000) begin
         bad++; $display("FAIL single_idle: busy=%b done=%b, want 0/0", d_busy, d_done);
      end
   endtask

   task automatic test_simultaneous();
      int n, d0, g0;
      logic [31:0] c;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      busy_reads = 1; echo = 1'b1;
      for (int k = 0; k < NREQ; k++) begin
         c = 32'h0000_0100 * (k + 1) + 32'((k + 1) << 17);
         cmd[32*k +: 32] = c;
         exp_q.push_back('{done: 4'(1 << k), status: {8'h00, c[23:0]}, tmo: 1'b0});
      end
      d0 = done_cnt; g0 = grant_log.size();
      req = 4'b1111;
      n = 0;
      while (done_cnt < d0 + 4 && n < 2000) begin @(negedge clk); n++; end
      req = '0;
      if (n >= 2000) begin total++; bad++; $display("FAIL simul_wait: %0d of 4 done", done_cnt - d0); end
      for (int k = 0; k < NREQ; k++) begin
         total++;
         if (grant_log.size() <= g0 + k || grant_log[g0 + k] != k) begin
            bad++; $display("FAIL simul_order: slot %0d got %0d want %0d", k,
                            (grant_log.size() > g0 + k) ? grant_log[g0 + k] : -1, k);
         end
      end
   endtask

   task automatic test_fairness();
      int n, d0, g0;
      int want[4] = '{0, 2, 0, 2};
      busy_reads = 0; echo = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back('{done: 4'(1 << want[k]), status: {8'h00, cmd[32*want[k] +: 24]}, tmo: 1'b0});
      end
      d0 = done_cnt; g0 = grant_log.size();
      @(negedge clk); req = 4'b0101;
      n = 0;
      while (done_cnt < d0 + 4 && n < 2000) begin @(negedge clk); n++; end
      req = '0;
      if (n >= 2000) begin total++; bad++; $display("FAIL fair_wait: %0d of 4 done", done_cnt - d0); end
      for (int k = 0; k < 4; k++) begin
         total++;
         if (grant_log.size() <= g0 + k || grant_log[g0 + k] != want[k]) begin
            bad++; $display("FAIL fair_order: slot %0d got %0d want %0d", k,
                            (grant_log.size() > g0 + k) ? grant_log[g0 + k] : -1, want[k]);
         end
      end
   endtask

   task automatic test_stall();
      int n, w0, d0;
      w0 = wr_cnt; d0 = done_cnt;
      busy_reads = 0; echo = 1'b0; final_status = 32'h0000_0077;
      cmd[31:0] = 32'h0012_3456;
      exp_q.push_back('{done: 4'b0001, status: 32'h0000_0077, tmo: 1'b0});
      @(negedge clk); req = 4'b0001; stall_drv = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k == 0) req = '0;
         total++;
         if (wb.cyc !== 1'b1 || wb.stb !== 1'b1 || wb.we !== 1'b1 || wb.wdata !== 32'h00123456 ||
             wb.addr !== 6'd0 || wb.sel !== 4'hf) begin
            bad++; $display("FAIL stall_hold: cycle %0d cyc=%b stb=%b we=%b data=%h addr=%h sel=%h",
                            k, wb.cyc, wb.stb, wb.we, wb.wdata, wb.addr, wb.sel);
         end
      end
      stall_drv = 1'b0;
      n = 0;
      while (done_cnt < d0 + 1 && n < 500) begin @(negedge clk); n++; end
      if (n >= 500) begin total++; bad++; $display("FAIL stall_wait: no done"); end
      total++;
      if (wr_cnt - w0 != 1) begin
         bad++; $display("FAIL stall_writes: got %0d want 1", wr_cnt - w0);
      end
   endtask

   task automatic test_error();
      int n;
      busy_reads = 1; echo = 1'b0; final_status = 32'h40A0_0000;
      exp_q.push_back('{done: 4'b1000, status: 32'h40A0_0000, tmo: 1'b0});
      @(negedge clk); req = 4'b1000;
      @(negedge clk); req = '0;
      n = 0;
      while (d_done === 4'b0000 && n < 500) begin @(negedge clk); n++; end
      total++;
      if (d_done !== 4'b1000 || d_status !== 32'h40A00000) begin
         bad++; $display("FAIL error_pass: done=%b status=%h, want 1000/40a00000", d_done, d_status);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int n, d0;
      busy_reads = 5; echo = 1'b0; final_status = 32'h0;
      d0 = done_cnt;
      @(negedge clk); req = 4'b0100;
      @(negedge clk);
      n = 0;
      while (!(wb.cyc === 1'b0 && d_busy === 1'b1) && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin total++; bad++; $display("FAIL rstmid_wait: never reached poll wait"); end
      #2 rst = 1'b1;
      #1;
      total++;
      if ({d_grant, d_done, d_tmo, d_busy, d_status, wb.cyc, wb.stb, wb.we, wb.sel, wb.wdata} !== 81'd0) begin
         bad++; $display("FAIL rstmid_async: grant=%b busy=%b status=%h cyc=%b data=%h, want 0",
                         d_grant, d_busy, d_status, wb.cyc, wb.wdata);
      end
      busy_reads = 0; echo = 1'b1;
      exp_q.push_back('{done: 4'b0001, status: {8'h00, cmd[23:0]}, tmo: 1'b0});
      @(negedge clk); rst = 1'b0; req = 4'b1001;
      @(negedge clk);
      total++;
      if (d_grant !== 4'b0001) begin
         bad++; $display("FAIL rstmid_grant: got %b want 0001", d_grant);
      end
      req = '0;
      n = 0;
      while (done_cnt < d0 + 1 && n < 500) begin @(negedge clk); n++; end
      if (n >= 500) begin total++; bad++; $display("FAIL rstmid_done: no done"); end
   endtask

`ifdef I2CARB_TIMEOUT_EN
   task automatic test_timeout();
      int n, r0;
      r0 = rd_cnt;
      busy_reads = 1000; echo = 1'b0;
      exp_q.push_back('{done: 4'b0010, status: BUSY_WORD | 32'h2000_0000, tmo: 1'b1});
      @(negedge clk); req = 4'b0010;
      @(negedge clk); req = '0;
      n = 0;
      while (d_done === 4'b0000 && n < 1000) begin @(negedge clk); n++; end
      total++;
      if (d_tmo !== 1'b1 || d_status[29] !== 1'b1 || rd_cnt - r0 != 8) begin
         bad++; $display("FAIL timeout_abort: tmo=%b status=%h reads=%0d, want 1/bit29/8", d_tmo, d_status, rd_cnt - r0);
      end
      @(negedge clk);
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_fairness();
      test_stall();
      test_error();
      test_reset_mid();
`ifdef I2CARB_TIMEOUT_EN
      test_timeout();
`endif
      repeat (3) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL sb_leftover: %0d completions never seen", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
